// File: rtl/pong_referee_if.sv
// Ball <-> referee link: the ball proposes a next position, the referee
// returns the registered position and single-cycle contact pulses.
interface pong_referee_if #(
  parameter int X_WIDTH = 10,
  parameter int Y_WIDTH = 10
);
  logic [X_WIDTH-1:0] newX;
  logic [Y_WIDTH-1:0] newY;
  logic [X_WIDTH-1:0] oldX;
  logic [Y_WIDTH-1:0] oldY;
  logic               touchingPaddle;
  logic               touchingWall;

  modport master (output newX, newY, input oldX, oldY, touchingPaddle, touchingWall);
  modport slave  (input newX, newY, output oldX, oldY, touchingPaddle, touchingWall);
endinterface

// File: rtl/pong_referee.sv
// Pong referee: closes the ball position loop, detects contact and misses,
// keeps score and sequences serve / play / point / game-over.
module pong_referee #(
  parameter int X_WIDTH        = 10,
  parameter int Y_WIDTH        = 10,
  parameter int SCREEN_W       = 640,
  parameter int SCREEN_H       = 480,
  parameter int BALL_SIZE      = 8,
  parameter int PADDLE_W       = 8,
  parameter int PADDLE_H       = 64,
  parameter int LEFT_PADDLE_X  = 16,
  parameter int RIGHT_PADDLE_X = 616,
  parameter int SERVE_FRAMES   = 60,
  parameter int WIN_SCORE      = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frameTick,
  input  logic               startGame,
  input  logic [Y_WIDTH-1:0] leftPaddleY,
  input  logic [Y_WIDTH-1:0] rightPaddleY,
  pong_referee_if.slave      ball,
  output logic [3:0]         scoreLeft,
  output logic [3:0]         scoreRight,
  output logic               playing,
  output logic               gameOver
);
  localparam int XE = X_WIDTH + 1;
  localparam int YE = Y_WIDTH + 1;
  localparam int CX = SCREEN_W/2 - BALL_SIZE/2;
  localparam int CY = SCREEN_H/2 - BALL_SIZE/2;
  localparam int CW = $clog2(SERVE_FRAMES + 1);

  typedef enum logic [1:0] {SERVE, PLAY, POINT, GAMEOVER} state_t;

  state_t             state, state_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [X_WIDTH-1:0] ox_n;
  logic [Y_WIDTH-1:0] oy_n;
  logic               tp_n, tw_n;
  logic [3:0]         sl_n, sr_n;

  // One extra bit of headroom so edge sums never wrap
  logic [XE-1:0] nx;
  logic [YE-1:0] ny, lpy, rpy;
  logic          left_miss, right_miss, hit_l, hit_r, wall;

  assign nx  = {1'b0, ball.newX};
  assign ny  = {1'b0, ball.newY};
  assign lpy = {1'b0, leftPaddleY};
  assign rpy = {1'b0, rightPaddleY};

  // newX past the playfield is a negative x that wrapped: treat as left miss
  assign left_miss  = (nx >= XE'(SCREEN_W)) || (nx + XE'(BALL_SIZE) <= XE'(LEFT_PADDLE_X));
  assign right_miss = nx >= XE'(RIGHT_PADDLE_X + PADDLE_W);

  assign hit_l = (nx < XE'(LEFT_PADDLE_X + PADDLE_W)) && (nx + XE'(BALL_SIZE) > XE'(LEFT_PADDLE_X)) &&
                 (ny < lpy + YE'(PADDLE_H)) && (ny + YE'(BALL_SIZE) > lpy);
  assign hit_r = (nx < XE'(RIGHT_PADDLE_X + PADDLE_W)) && (nx + XE'(BALL_SIZE) > XE'(RIGHT_PADDLE_X)) &&
                 (ny < rpy + YE'(PADDLE_H)) && (ny + YE'(BALL_SIZE) > rpy);
  assign wall  = (ny == '0) || (ny >= YE'(SCREEN_H - BALL_SIZE));

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ox_n    = ball.oldX;
    oy_n    = ball.oldY;
    tp_n    = 1'b0;
    tw_n    = 1'b0;
    sl_n    = scoreLeft;
    sr_n    = scoreRight;
    unique case (state)
      SERVE: begin
        ox_n = X_WIDTH'(CX);
        oy_n = Y_WIDTH'(CY);
        if (frameTick) begin
          if (cnt == CW'(SERVE_FRAMES - 1)) begin
            cnt_n   = '0;
            state_n = PLAY;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      PLAY: if (frameTick) begin
        if (left_miss) begin
          sr_n    = (scoreRight == 4'd15) ? scoreRight : scoreRight + 4'd1;
          state_n = POINT;
        end else if (right_miss) begin
          sl_n    = (scoreLeft == 4'd15) ? scoreLeft : scoreLeft + 4'd1;
          state_n = POINT;
        end else begin
          ox_n = ball.newX;
          oy_n = ball.newY;
          tp_n = hit_l | hit_r;
          tw_n = wall;
        end
      end
      POINT: begin
        ox_n    = X_WIDTH'(CX);
        oy_n    = Y_WIDTH'(CY);
        state_n = (scoreLeft == 4'(WIN_SCORE) || scoreRight == 4'(WIN_SCORE)) ? GAMEOVER : SERVE;
      end
      GAMEOVER: begin
        ox_n = X_WIDTH'(CX);
        oy_n = Y_WIDTH'(CY);
        if (startGame) begin
          sl_n    = '0;
          sr_n    = '0;
          cnt_n   = '0;
          state_n = SERVE;
        end
      end
      default: state_n = SERVE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state               <= SERVE;
      cnt                 <= '0;
      ball.oldX           <= X_WIDTH'(CX);
      ball.oldY           <= Y_WIDTH'(CY);
      ball.touchingPaddle <= 1'b0;
      ball.touchingWall   <= 1'b0;
      scoreLeft           <= '0;
      scoreRight          <= '0;
      playing             <= 1'b0;
      gameOver            <= 1'b0;
    end else begin
      state               <= state_n;
      cnt                 <= cnt_n;
      ball.oldX           <= ox_n;
      ball.oldY           <= oy_n;
      ball.touchingPaddle <= tp_n;
      ball.touchingWall   <= tw_n;
      scoreLeft           <= sl_n;
      scoreRight          <= sr_n;
      playing             <= (state_n == PLAY);
      gameOver            <= (state_n == GAMEOVER);
    end
  end
endmodule

// File: tb/tb_pong_referee.sv
// Directed plus randomized bench for pong_referee against a signed-integer
// model of the referee rules.
module tb_pong_referee;
  localparam int CX = 316, CY = 236;
  localparam int P_SERVE = 0, P_PLAY = 1, P_POINT = 2, P_OVER = 3;

  logic       clk = 1'b0, rst = 1'b0, frameTick = 1'b0, startGame = 1'b0;
  logic [9:0] leftPaddleY = '0, rightPaddleY = '0;
  logic [3:0] scoreLeft, scoreRight;
  logic       playing, gameOver;

  pong_referee_if #(.X_WIDTH(10), .Y_WIDTH(10)) bif();

  pong_referee dut (
    .clk(clk), .rst(rst), .frameTick(frameTick), .startGame(startGame),
    .leftPaddleY(leftPaddleY), .rightPaddleY(rightPaddleY), .ball(bif),
    .scoreLeft(scoreLeft), .scoreRight(scoreRight), .playing(playing), .gameOver(gameOver)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int m_ph, m_cnt, m_sl, m_sr, m_ox, m_oy, m_tp, m_tw;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_ph = P_SERVE; m_cnt = 0; m_sl = 0; m_sr = 0;
    m_ox = CX; m_oy = CY; m_tp = 0; m_tw = 0;
  endfunction

  function automatic bit overlap(int x, int px, int y, int py);
    return (x < px + 8) && (x + 8 > px) && (y < py + 64) && (y + 8 > py);
  endfunction

  function automatic void model_step(bit ft, bit sg, int nx, int ny, int lp, int rp);
    int x;
    m_tp = 0; m_tw = 0;
    case (m_ph)
      P_SERVE: begin
        m_ox = CX; m_oy = CY;
        if (ft) begin
          m_cnt++;
          if (m_cnt == 60) begin m_cnt = 0; m_ph = P_PLAY; end
        end
      end
      P_PLAY: if (ft) begin
        x = (nx >= 640) ? nx - 1024 : nx;
        if (x + 8 <= 16) begin
          m_sr = (m_sr < 15) ? m_sr + 1 : 15; m_ph = P_POINT;
        end else if (x >= 624) begin
          m_sl = (m_sl < 15) ? m_sl + 1 : 15; m_ph = P_POINT;
        end else begin
          m_tp = int'(overlap(x, 16, ny, lp) || overlap(x, 616, ny, rp));
          m_tw = int'(ny == 0 || ny >= 472);
          m_ox = nx; m_oy = ny;
        end
      end
      P_POINT: begin
        m_ox = CX; m_oy = CY;
        m_ph = (m_sl == 7 || m_sr == 7) ? P_OVER : P_SERVE;
      end
      default: if (sg) begin
        m_sl = 0; m_sr = 0; m_cnt = 0; m_ph = P_SERVE;
      end
    endcase
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".oldX"}, 32'(bif.oldX), m_ox);
    chk({tag, ".oldY"}, 32'(bif.oldY), m_oy);
    chk({tag, ".touchingPaddle"}, 32'(bif.touchingPaddle), m_tp);
    chk({tag, ".touchingWall"}, 32'(bif.touchingWall), m_tw);
    chk({tag, ".scoreLeft"}, 32'(scoreLeft), m_sl);
    chk({tag, ".scoreRight"}, 32'(scoreRight), m_sr);
    chk({tag, ".playing"}, 32'(playing), int'(m_ph == P_PLAY));
    chk({tag, ".gameOver"}, 32'(gameOver), int'(m_ph == P_OVER));
  endtask

  task automatic cycle(input string tag, input bit ft, input bit sg, input int nx, input int ny);
    frameTick = ft; startGame = sg;
    bif.newX = nx[9:0]; bif.newY = ny[9:0];
    @(posedge clk); #1;
    model_step(ft, sg, nx, ny, int'(leftPaddleY), int'(rightPaddleY));
    frameTick = 1'b0; startGame = 1'b0;
    check_all(tag);
  endtask

  task automatic serve(input string tag);
    for (int i = 0; i < 60; i++) cycle(tag, 1'b1, 1'b0, 316, 236);
  endtask

  initial begin
    int nx, ny;
    bit ft, sg;
    bif.newX = '0; bif.newY = '0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk) rst = 1'b1;

    serve("serve");
    chk("serve_to_play", 32'(playing), 1);

    cycle("wall", 1'b1, 1'b0, 300, 0);
    chk("wall_pulse", 32'(bif.touchingWall), 1);
    cycle("wall_clear", 1'b0, 1'b0, 300, 0);

    leftPaddleY = 10'd100;
    cycle("lpad_hit", 1'b1, 1'b0, 20, 120);
    chk("lpad_pulse", 32'(bif.touchingPaddle), 1);
    cycle("lpad_clear", 1'b0, 1'b0, 20, 120);
    cycle("lpad_below", 1'b1, 1'b0, 20, 170);

    rightPaddleY = 10'd0;
    cycle("corner", 1'b1, 1'b0, 612, 0);
    chk("corner_both", 32'({bif.touchingPaddle, bif.touchingWall}), 3);

    cycle("wrap_miss", 1'b1, 1'b0, 1020, 200);
    chk("wrap_score", 32'(scoreRight), 1);
    cycle("point", 1'b0, 1'b0, 0, 0);
    chk("point_centre", 32'({bif.oldX, bif.oldY}), (CX << 10) | CY);

    for (int k = 0; k < 7; k++) begin
      serve("serve_k");
      cycle("rmiss", 1'b1, 1'b0, 630, 100);
      cycle("rpoint", 1'b0, 1'b0, 0, 0);
    end
    chk("game_over", 32'(gameOver), 1);
    for (int i = 0; i < 5; i++) cycle("over_ignore", 1'b1, 1'b0, 630, 100);
    cycle("restart", 1'b0, 1'b1, 0, 0);
    chk("restart_scores", 32'({scoreLeft, scoreRight}), 0);
    for (int i = 0; i < 10; i++) cycle("serve_pre_rst", 1'b1, 1'b0, 0, 0);

    // asynchronous reset mid-serve, checked before any clock edge
    #3 rst = 1'b0;
    #1 model_reset();
    check_all("async_rst");
    @(negedge clk) rst = 1'b1;
    serve("serve_post_rst");
    chk("counter_cleared", 32'(playing), 1);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 31) == 0) begin
        leftPaddleY  = 10'($urandom_range(0, 416));
        rightPaddleY = 10'($urandom_range(0, 416));
      end
      case ($urandom_range(0, 3))
        0:       nx = int'($urandom_range(0, 1023));
        1:       nx = int'($urandom_range(0, 40));
        2:       nx = int'($urandom_range(600, 639));
        default: nx = int'($urandom_range(100, 540));
      endcase
      case ($urandom_range(0, 3))
        0:       ny = 0;
        1:       ny = int'($urandom_range(465, 520));
        default: ny = int'($urandom_range(0, 479));
      endcase
      ft = ($urandom_range(0, 2) != 0);
      sg = ($urandom_range(0, 15) == 0);
      cycle("random", ft, sg, nx, ny);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
